// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters (req0 = execute stage,
// req1 = auxiliary unit). Requests are arbitrated round-robin with
// valid/ready handshakes. The ALU result of an accepted request is captured
// into a single result register and returned to the requester that issued it.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqX_valid / reqX_ready    request handshake, X = 0/1
//   reqX_op, reqX_a, reqX_b    opcode and operands of requester X
//   rspX_valid / rspX_ready    response handshake, X = 0/1
//   rsp_data, rsp_zero         registered ALU result and zero flag (shared)
//   alu_op, alu_a, alu_b       drive the external ALU inputs
//   alu_d, alu_zero            external ALU result and zero flag
// ---------------------------------------------------------------------------
`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif

module alu_arbiter #(
  parameter int WIDTH = `REG_FILE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,

  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_zero
);

  typedef enum logic {
    ST_IDLE = 1'b0,   // result register empty
    ST_RESP = 1'b1    // result register holds a result for rsp_id_q
  } state_t;

  state_t           state_q, state_d;
  logic             rsp_id_q, rsp_id_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic owner_ready;   // the current result owner consumes its result
  logic slot_free;     // result register can take a new result this cycle
  logic any_valid;
  logic grant;         // round-robin winner (0 or 1), meaningful if any_valid
  logic accept;        // the winner is accepted this cycle

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    owner_ready = rsp_id_q ? rsp1_ready : rsp0_ready;
    // The non-owner's rsp_ready never frees the slot.
    slot_free   = (state_q == ST_IDLE) || owner_ready;
    any_valid   = req0_valid || req1_valid;

    // On a tie the requester that did not win last time gets the slot;
    // otherwise the single valid requester wins.
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end

    accept = slot_free && any_valid;
  end

  assign req0_ready = accept && (grant == 1'b0);
  assign req1_ready = accept && (grant == 1'b1);

  // -------------------------------------------------------------------------
  // ALU input mux: the current winner's fields are presented even while the
  // slot is blocked; they only become a committed operation on accept.
  // -------------------------------------------------------------------------
  always_comb begin
    alu_op = 4'h0;
    alu_a  = '0;
    alu_b  = '0;
    if (any_valid) begin
      if (grant) begin
        alu_op = req1_op;
        alu_a  = req1_a;
        alu_b  = req1_b;
      end else begin
        alu_op = req0_op;
        alu_a  = req0_a;
        alu_b  = req0_b;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Owner consumed and nothing new accepted: slot empties. With a
        // new accept the state stays RESP and the result is replaced.
        if (owner_ready && !accept) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      rsp_id_d     = grant;
      last_grant_d = grant;
      rsp_data_d   = alu_d;
      rsp_zero_d   = alu_zero;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;   // req0 wins the first tie
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  // -------------------------------------------------------------------------
  // Response outputs
  // -------------------------------------------------------------------------
  assign rsp0_valid = (state_q == ST_RESP) && (rsp_id_q == 1'b0);
  assign rsp1_valid = (state_q == ST_RESP) && (rsp_id_q == 1'b1);
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small ALU model (add/sub/and/or, default
// add) closes the loop around the arbiter. Expected values are hand-computed
// constants. Inputs change 1 ns after the rising edge; outputs are sampled
// 1-2 ns after the edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [3:0]   req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [3:0]   req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready;
  logic         rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_d;
  logic         alu_zero;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_d      (alu_d),
    .alu_zero   (alu_zero)
  );

  // External ALU model: unknown opcodes fall back to add.
  always_comb begin
    case (alu_op)
      4'h1:    alu_d = alu_a - alu_b;
      4'h2:    alu_d = alu_a & alu_b;
      4'h3:    alu_d = alu_a | alu_b;
      default: alu_d = alu_a + alu_b;
    endcase
    alu_zero = (alu_d == '0);
  end

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req0(input logic v, input logic [3:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive_req1(input logic v, input logic [3:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  // Checks a delivered response and prints one line for the transaction.
  task automatic expect_rsp(input string tag, input logic id,
                            input logic [W-1:0] data, input logic zero);
    check_eq({tag, "_v0"},   64'(rsp0_valid), 64'(id == 1'b0));
    check_eq({tag, "_v1"},   64'(rsp1_valid), 64'(id == 1'b1));
    check_eq({tag, "_data"}, 64'(rsp_data),   64'(data));
    check_eq({tag, "_zero"}, 64'(rsp_zero),   64'(zero));
    $display("txn %s: id=%0d data=%0d zero=%0d", tag, rsp1_valid, rsp_data, rsp_zero);
  endtask

  // Hand-computed fairness sequence: req0 ADD (i+1)+10, req1 SUB 100-(i+1).
  logic [W-1:0] fair_data [4] = '{32'd11, 32'd99, 32'd12, 32'd98};
  logic         fair_id   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n1;
    rst_n = 1'b0;
    drive_req0(1'b0, 4'h0, '0, '0);
    drive_req1(1'b0, 4'h0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Reset state
    #12;
    check_eq("rst_rdy0",  64'(req0_ready), 64'd0);
    check_eq("rst_rdy1",  64'(req1_ready), 64'd0);
    check_eq("rst_v0",    64'(rsp0_valid), 64'd0);
    check_eq("rst_v1",    64'(rsp1_valid), 64'd0);
    check_eq("rst_data",  64'(rsp_data),   64'd0);
    check_eq("rst_zero",  64'(rsp_zero),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // req0 ADD 5+3, accepted on the first edge it is presented
    drive_req0(1'b1, 4'h0, 32'd5, 32'd3);
    rsp0_ready = 1'b1;
    #1;
    check_eq("add_rdy0", 64'(req0_ready), 64'd1);
    check_eq("add_rdy1", 64'(req1_ready), 64'd0);
    check_eq("add_aluop", 64'(alu_op), 64'h0);
    tick();
    drive_req0(1'b0, 4'h0, '0, '0);
    expect_rsp("add", 1'b0, 32'd8, 1'b0);

    // req1 SUB 7-7 -> zero result, taken back-to-back with req0 consuming
    drive_req1(1'b1, 4'h1, 32'd7, 32'd7);
    rsp1_ready = 1'b1;
    #1;
    check_eq("sub_rdy1", 64'(req1_ready), 64'd1);
    tick();
    drive_req1(1'b0, 4'h0, '0, '0);
    expect_rsp("sub", 1'b1, 32'd0, 1'b1);

    // Idle cycle drains the slot
    tick();
    check_eq("drain_v1", 64'(rsp1_valid), 64'd0);

    // Fairness: both valid every cycle, responses always consumed
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      drive_req0(1'b1, 4'h0, W'(n0 + 1), 32'd10);
      drive_req1(1'b1, 4'h1, 32'd100, W'(n1 + 1));
      #1;
      check_eq($sformatf("fair%0d_rdy0", i), 64'(req0_ready), 64'(fair_id[i] == 1'b0));
      check_eq($sformatf("fair%0d_rdy1", i), 64'(req1_ready), 64'(fair_id[i] == 1'b1));
      tick();
      expect_rsp($sformatf("fair%0d", i), fair_id[i], fair_data[i], 1'b0);
      if (fair_id[i]) n1++; else n0++;
    end
    drive_req1(1'b0, 4'h0, '0, '0);

    // Backpressure: req0 result held while req1 waits; rsp1_ready ignored
    drive_req0(1'b1, 4'h0, 32'd20, 32'd22);
    rsp0_ready = 1'b0;
    #1;
    check_eq("bp_acc_rdy0", 64'(req0_ready), 64'd1);
    tick();
    drive_req0(1'b0, 4'h0, '0, '0);
    drive_req1(1'b1, 4'h0, 32'd1, 32'd1);
    expect_rsp("bp_hold", 1'b0, 32'd42, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("bp%0d_rdy1", i), 64'(req1_ready), 64'd0);
      check_eq($sformatf("bp%0d_data", i), 64'(rsp_data),   64'd42);
      check_eq($sformatf("bp%0d_v0", i),   64'(rsp0_valid), 64'd1);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy1", 64'(req1_ready), 64'd1);
    tick();
    drive_req1(1'b0, 4'h0, '0, '0);
    expect_rsp("bp_next", 1'b1, 32'd2, 1'b0);

    // Make req0 the last winner and hold its result
    drive_req0(1'b1, 4'h0, 32'd4, 32'd4);
    rsp0_ready = 1'b0;
    tick();
    drive_req0(1'b0, 4'h0, '0, '0);
    expect_rsp("pre_rst", 1'b0, 32'd8, 1'b0);

    // Asynchronous reset mid-cycle while RESP
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_v0",   64'(rsp0_valid), 64'd0);
    check_eq("arst_v1",   64'(rsp1_valid), 64'd0);
    check_eq("arst_data", 64'(rsp_data),   64'd0);
    #1;
    rst_n = 1'b1;
    drive_req0(1'b1, 4'h0, 32'd1, 32'd1);
    drive_req1(1'b1, 4'h0, 32'd2, 32'd2);
    rsp0_ready = 1'b1;
    #1;
    check_eq("arst_tie_rdy0", 64'(req0_ready), 64'd1);
    check_eq("arst_tie_rdy1", 64'(req1_ready), 64'd0);
    tick();
    drive_req0(1'b0, 4'h0, '0, '0);
    drive_req1(1'b0, 4'h0, '0, '0);
    expect_rsp("arst_tie", 1'b0, 32'd2, 1'b0);

    // Unknown opcode forwarded unchanged, ALU falls back to add
    drive_req0(1'b1, 4'hF, 32'd2, 32'd3);
    #1;
    check_eq("unk_aluop", 64'(alu_op),     64'hF);
    check_eq("unk_rdy0",  64'(req0_ready), 64'd1);
    tick();
    drive_req0(1'b0, 4'h0, '0, '0);
    expect_rsp("unk", 1'b0, 32'd5, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer that shares the single combinational `alu` between two requesters (req0: execute stage, req1: auxiliary unit such as address/branch calculation). Round-robin arbitration with valid/ready handshakes on both sides. Drives the ALU operand/opcode inputs and captures `regD`/`zero` into a one-entry result register, returning each result to the requester that issued it.

## Interface
- `WIDTH`, default `` `REG_FILE_WIDTH `` (from `header.vh`): operand/result width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 presents an operation.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_op` in 4: ALU opcode.
- `req0_a`, `req0_b` in WIDTH: ALU operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as req0, for requester 1.
- `rsp0_valid` out 1: result register holds a result for requester 0.
- `rsp0_ready` in 1: requester 0 consumes the result.
- `rsp1_valid`, `rsp1_ready`: same as rsp0, for requester 1.
- `rsp_data` out WIDTH: registered ALU result, shared by both requesters.
- `rsp_zero` out 1: registered ALU zero flag.
- `alu_op` out 4: drives ALU `op`.
- `alu_a`, `alu_b` out WIDTH: drive ALU `regA`/`regB`.
- `alu_d` in WIDTH: from ALU `regD`.
- `alu_zero` in 1: from ALU `zero`.

## Operation
- States: IDLE (result register empty) and RESP (result register full, `rsp_id` records the owner).
- Slot free this cycle: `free = (state==IDLE) || (state==RESP && rspX_ready for owner X)`.
- Grant:
  - Only one requester valid: it wins.
  - Both valid: the one not granted last (`last_grant`) wins.
  - `last_grant` resets to 1, so req0 wins the first tie.
  - `last_grant` updates only on an accepted request.
- `reqX_ready = free && (grant == X)`; never asserted for both requesters in the same cycle. `reqX_ready` is combinational on `rspY_ready`.
- Accept (`reqX_valid && reqX_ready`):
  - `alu_op`/`alu_a`/`alu_b` = requester X's fields in that cycle.
  - At the edge: `rsp_data <= alu_d`, `rsp_zero <= alu_zero`, `rsp_id <= X`, state → RESP.
- No accept: ALU inputs driven with the current round-robin winner's fields if any valid, else all zero.
- Opcodes pass through unchanged; unknown opcodes are handled by the ALU (add), not the arbiter.
- RESP:
  - `rspX_valid = 1` only for `rsp_id`.
  - `rsp_data`/`rsp_zero` are stable until the owner's ready.
  - Owner ready with no new accept → IDLE.
  - Owner ready with a new accept → stay in RESP and load the new result (back-to-back).
- `rsp_ready` of the non-owner is ignored.
- Requester rules: `reqX_valid` must stay high with stable op/a/b until accepted. A deasserted valid with no accept is legal and has no effect.

## Timing
- Reset values: `req0_ready`=0, `req1_ready`=0, `rsp0_valid`=0, `rsp1_valid`=0, `rsp_data`=0, `rsp_zero`=0, state=IDLE, `rsp_id`=0, `last_grant`=1.
- Asynchronous assert at any time, including mid-RESP: the pending result is discarded and nothing is replayed. First accept is possible on the first edge after deassert.
- Latency: accept at edge N → `rspX_valid`=1 after edge N (visible in cycle N+1).
- Throughput: one operation per cycle when the owner holds `rsp_ready`=1 continuously.
- Fairness: with both valid and responses always consumed, grants alternate 0,1,0,1…
- Backpressure: while RESP and the owner's ready is 0, both `req_ready`=0 and the ALU inputs carry no committed operation.
- Single flop stage: results are captured on the accept edge only, never held combinationally.

## Test plan
- Reset, then req0 ADD (op=0, a=5, b=3), `rsp0_ready`=1 → `req0_ready`=1 in cycle 0; `rsp0_valid`=1, `rsp_data`=8, `rsp_zero`=0 in cycle 1; `rsp1_valid` stays 0.
- req1 SUB (op=1, a=7, b=7) → `rsp1_valid`, `rsp_data`=0, `rsp_zero`=1.
- Both valid every cycle, responses always ready → grants 0,1,0,1, one result per cycle, each `rsp_id` matching its issuer.
- req0 result pending with `rsp0_ready`=0 for 4 cycles while req1 is valid → `req1_ready`=0 and `rsp_data` stable throughout. Raise `rsp0_ready` → req1 accepted in that same cycle, its result in the next.
- `rst_n` pulsed low asynchronously mid-cycle while RESP → `rsp0_valid`/`rsp1_valid` drop immediately, `rsp_data`=0, and the next tie is granted to req0.
- Unknown op (4'hF, a=2, b=3) → `alu_op`=4'hF forwarded unchanged, `rsp_data`=5 (ALU default add).
